// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the memory port arbiter
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    MEM_BUSY = 2'd2,
    DONE     = 2'd3
  } arb_state_t;

  localparam logic [1:0] LM_WORD   = 2'b00;
  localparam logic [1:0] LM_HALF_S = 2'b01;
  localparam logic [1:0] LM_HALF_U = 2'b10;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter and access sequencer for a single-ported memory
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [1:0]        load_mode,
  input  logic              ram_ready,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [1:0]        ram_load_mode,
  output logic              if_done,
  output logic              mem_done,
  output logic [DATA_W-1:0] rdata,
  output logic              stall_if,
  output logic              stall_pipe
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  arb_state_t        state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              served_if_q, served_if_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        lm_q, lm_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic data_req;
  logic data_win;

  assign data_req = mem_read | mem_write;
  // Data has priority until it has taken MAX_STREAK grants in a row over a waiting fetch.
  assign data_win = data_req && ((streak_q < STREAK_MAX) || !if_req);

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    served_if_d = served_if_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lm_d        = lm_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (data_win) begin
          state_d     = MEM_BUSY;
          served_if_d = 1'b0;
          we_d        = mem_write;
          addr_d      = mem_addr;
          wdata_d     = mem_wdata;
          lm_d        = load_mode;
          if (!if_req) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + SW'(1);
          end
        end else if (if_req) begin
          state_d     = IF_BUSY;
          served_if_d = 1'b1;
          we_d        = 1'b0;
          addr_d      = if_addr;
          wdata_d     = '0;
          lm_d        = LM_WORD;
          streak_d    = '0;
        end
      end
      IF_BUSY, MEM_BUSY: begin
        if (ram_ready) begin
          rdata_d = ram_rdata;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      served_if_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lm_q        <= LM_WORD;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      served_if_q <= served_if_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lm_q        <= lm_d;
      rdata_q     <= rdata_d;
    end
  end

  // Request qualifiers only count while the memory is actually engaged.
  assign ram_en        = (state_q == IF_BUSY) || (state_q == MEM_BUSY);
  assign ram_we        = ram_en & we_q;
  assign ram_addr      = addr_q;
  assign ram_wdata     = wdata_q;
  assign ram_load_mode = lm_q;
  assign if_done       = (state_q == DONE) && served_if_q;
  assign mem_done      = (state_q == DONE) && !served_if_q;
  assign rdata         = rdata_q;
  assign stall_if      = if_req & ~if_done;
  assign stall_pipe    = data_req & ~mem_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  load_mode;
  logic        ram_ready;
  logic [31:0] ram_rdata;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [1:0]  ram_load_mode;
  logic        if_done;
  logic        mem_done;
  logic [31:0] rdata;
  logic        stall_if;
  logic        stall_pipe;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .load_mode(load_mode),
    .ram_ready(ram_ready), .ram_rdata(ram_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_load_mode(ram_load_mode), .if_done(if_done), .mem_done(mem_done),
    .rdata(rdata), .stall_if(stall_if), .stall_pipe(stall_pipe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_addr = '0; mem_wdata = '0; load_mode = 2'b00; ram_ready = 1'b0; ram_rdata = '0;
    step(); step();
    @(negedge clk);
    checks++;
    if ({ram_en, ram_we, if_done, mem_done, stall_if, stall_pipe} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000", {ram_en, ram_we, if_done, mem_done, stall_if, stall_pipe});
    end
    checks++;
    if (ram_addr !== 32'h0 || ram_wdata !== 32'h0 || rdata !== 32'h0 || ram_load_mode !== 2'b00) begin
      errors++;
      $display("FAIL reset_data: got addr %h wdata %h rdata %h lm %b want all zero", ram_addr, ram_wdata, rdata, ram_load_mode);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    checks++;
    if (stall_if !== 1'b1 || ram_en !== 1'b0) begin
      errors++;
      $display("FAIL fetch_c0: stall_if %b ram_en %b want 1 0", stall_if, ram_en);
    end
    step();
    ram_ready = 1'b1; ram_rdata = 32'h2002000A;
    @(negedge clk);
    checks++;
    if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 32'h40 || ram_load_mode !== 2'b00 || stall_if !== 1'b1 || if_done !== 1'b0) begin
      errors++;
      $display("FAIL fetch_c1: en %b we %b addr %h lm %b stall %b done %b want 1 0 00000040 00 1 0",
               ram_en, ram_we, ram_addr, ram_load_mode, stall_if, if_done);
    end
    step();
    ram_ready = 1'b0; ram_rdata = '0;
    @(negedge clk);
    checks++;
    if (if_done !== 1'b1 || mem_done !== 1'b0 || rdata !== 32'h2002000A || stall_if !== 1'b0 || ram_en !== 1'b0) begin
      errors++;
      $display("FAIL fetch_c2: if_done %b mem_done %b rdata %h stall %b en %b want 1 0 2002000a 0 0",
               if_done, mem_done, rdata, stall_if, ram_en);
    end
    step();
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_done !== 1'b0 || rdata !== 32'h2002000A) begin
      errors++;
      $display("FAIL fetch_after: if_done %b rdata %h want 0 2002000a", if_done, rdata);
    end
  endtask

  task automatic test_store_load();
    int pulses;
    pulses = 0;
    mem_write = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hDEADBEEF; load_mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      ram_ready = (i == 2);
      @(negedge clk);
      if (mem_done) pulses++;
      checks++;
      if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 32'h100 || ram_wdata !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL store_busy[%0d]: en %b we %b addr %h wdata %h want 1 1 00000100 deadbeef",
                 i, ram_en, ram_we, ram_addr, ram_wdata);
      end
    end
    step();
    ram_ready = 1'b0;
    @(negedge clk);
    if (mem_done) pulses++;
    checks++;
    if (ram_en !== 1'b0 || stall_pipe !== 1'b0) begin
      errors++;
      $display("FAIL store_done: en %b stall_pipe %b want 0 0", ram_en, stall_pipe);
    end
    step();
    mem_write = 1'b0;
    @(negedge clk);
    if (mem_done) pulses++;
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL store_pulses: got %0d want 1", pulses);
    end
    mem_read = 1'b1; mem_addr = 32'h104; load_mode = 2'b01;
    step();
    ram_ready = 1'b1; ram_rdata = 32'h0000ABCD;
    @(negedge clk);
    checks++;
    if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_load_mode !== 2'b01 || ram_addr !== 32'h104) begin
      errors++;
      $display("FAIL load_busy: en %b we %b lm %b addr %h want 1 0 01 00000104", ram_en, ram_we, ram_load_mode, ram_addr);
    end
    step();
    ram_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_done !== 1'b1 || rdata !== 32'h0000ABCD) begin
      errors++;
      $display("FAIL load_done: mem_done %b rdata %h want 1 0000abcd", mem_done, rdata);
    end
    step();
    mem_read = 1'b0; load_mode = 2'b00;
  endtask

  task automatic test_contention();
    logic [31:0] exp_order [8];
    logic [31:0] got [8];
    int n;
    logic prev_en;
    exp_order = '{32'h200, 32'h200, 32'h200, 32'h40, 32'h200, 32'h200, 32'h200, 32'h40};
    n = 0;
    prev_en = 1'b0;
    if_req = 1'b1; if_addr = 32'h40;
    mem_read = 1'b1; mem_addr = 32'h200;
    ram_ready = 1'b1; ram_rdata = 32'h55AA55AA;
    for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
      @(negedge clk);
      if (ram_en && !prev_en) begin
        got[n] = ram_addr;
        n++;
      end
      prev_en = ram_en;
    end
    step();
    if_req = 1'b0; mem_read = 1'b0;
    step(); step(); step();
    ram_ready = 1'b0;
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL contention_count: got %0d grants want 8", n);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got[k] !== exp_order[k]) begin
        errors++;
        $display("FAIL contention_grant[%0d]: addr %h want %h", k, got[k], exp_order[k]);
      end
    end
  endtask

  task automatic test_spurious_ready();
    ram_ready = 1'b1; ram_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      checks++;
      if (ram_en !== 1'b0 || if_done !== 1'b0 || mem_done !== 1'b0 || rdata !== 32'h55AA55AA) begin
        errors++;
        $display("FAIL spurious_ready[%0d]: en %b if_done %b mem_done %b rdata %h want 0 0 0 55aa55aa",
                 i, ram_en, if_done, mem_done, rdata);
      end
    end
    step();
    ram_ready = 1'b0;
  endtask

  task automatic test_read_write();
    mem_read = 1'b1; mem_write = 1'b1; mem_addr = 32'h300; mem_wdata = 32'h12345678; load_mode = 2'b10;
    step();
    ram_ready = 1'b1; ram_rdata = 32'h0BADF00D;
    @(negedge clk);
    checks++;
    if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_load_mode !== 2'b10 || ram_wdata !== 32'h12345678) begin
      errors++;
      $display("FAIL rw_busy: en %b we %b lm %b wdata %h want 1 1 10 12345678", ram_en, ram_we, ram_load_mode, ram_wdata);
    end
    step();
    ram_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_done !== 1'b1 || if_done !== 1'b0) begin
      errors++;
      $display("FAIL rw_done: mem_done %b if_done %b want 1 0", mem_done, if_done);
    end
    step();
    mem_read = 1'b0; mem_write = 1'b0; load_mode = 2'b00;
    step();
  endtask

  task automatic test_reset_mid_access();
    mem_read = 1'b1; mem_addr = 32'h400;
    step();
    @(negedge clk);
    checks++;
    if (ram_en !== 1'b1 || ram_addr !== 32'h400) begin
      errors++;
      $display("FAIL rst_mid_busy: en %b addr %h want 1 00000400", ram_en, ram_addr);
    end
    rst_n = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if (ram_en !== 1'b0 || mem_done !== 1'b0 || ram_addr !== 32'h0 || rdata !== 32'h0 || stall_pipe !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_reset: en %b mem_done %b addr %h rdata %h stall_pipe %b want 0 0 00000000 00000000 1",
               ram_en, mem_done, ram_addr, rdata, stall_pipe);
    end
    step();
    rst_n = 1'b1; mem_addr = 32'h404;
    @(negedge clk);
    checks++;
    if (mem_done !== 1'b0 || ram_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_release: mem_done %b en %b want 0 0", mem_done, ram_en);
    end
    step();
    ram_ready = 1'b1; ram_rdata = 32'hCAFEF00D;
    @(negedge clk);
    checks++;
    if (ram_en !== 1'b1 || ram_addr !== 32'h404) begin
      errors++;
      $display("FAIL rst_mid_fresh_busy: en %b addr %h want 1 00000404", ram_en, ram_addr);
    end
    step();
    ram_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_done !== 1'b1 || rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL rst_mid_fresh_done: mem_done %b rdata %h want 1 cafef00d", mem_done, rdata);
    end
    step();
    mem_read = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_contention();
    test_spurious_ready();
    test_read_write();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
